// File: rtl/adder_arbiter_if.sv
// Bundle of requester-lane and shared-adder signals for adder_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface adder_arbiter_if;
    logic [3:0]  req;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [11:0] res;
    logic [1:0]  add_a;
    logic [1:0]  add_b;
    logic        add_go;
    logic [2:0]  add_sum;
    logic        busy;

    modport slave (
        input  req, op_a, op_b, add_sum,
        output gnt, done, res, add_a, add_b, add_go, busy
    );

    modport master (
        output req, op_a, op_b, add_sum,
        input  gnt, done, res, add_a, add_b, add_go, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one 2-bit adder of latency ADD_LAT among
// four lanes, capturing each lane's 3-bit sum and pulsing its done bit.
module adder_arbiter #(
    parameter int ADD_LAT = 1
) (
    input logic             clk,
    input logic             reset,
    adder_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  last;
    logic [1:0]  lane;
    logic [1:0]  pick_lane;
    logic [2:0]  cnt;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;

    logic [3:0]  gnt_r;
    logic [3:0]  done_r;
    logic [11:0] res_r;
    logic [1:0]  add_a_r;
    logic [1:0]  add_b_r;
    logic        add_go_r;
    logic        busy_r;

    // Later loop iterations win, so iterating from offset 4 down to 1 leaves the
    // nearest set bit after 'last'; 'last' itself (offset 4) has lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] c;
        rr_pick = l;
        for (int i = 4; i >= 1; i--) begin
            c = l + 2'(i);
            if (r[c]) rr_pick = c;
        end
    endfunction

    always_comb begin
        pick_lane = rr_pick(bus.req, last);
        sel_a     = 2'(bus.op_a >> {pick_lane, 1'b0});
        sel_b     = 2'(bus.op_b >> {pick_lane, 1'b0});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|bus.req) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (cnt == 3'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All outputs are registered from next_state so nothing leaks combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= 2'd3;
            lane     <= 2'd0;
            cnt      <= 3'd0;
            gnt_r    <= 4'd0;
            done_r   <= 4'd0;
            res_r    <= 12'd0;
            add_a_r  <= 2'd0;
            add_b_r  <= 2'd0;
            add_go_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            add_go_r <= (next_state == ISSUE);
            busy_r   <= (next_state != IDLE);
            done_r   <= 4'd0;
            case (state)
                IDLE: begin
                    if (next_state == ISSUE) begin
                        lane    <= pick_lane;
                        gnt_r   <= 4'(4'b0001 << pick_lane);
                        add_a_r <= sel_a;
                        add_b_r <= sel_b;
                    end
                end
                ISSUE: cnt <= 3'(ADD_LAT);
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        done_r <= gnt_r;
                        for (int i = 0; i < 4; i++) begin
                            if (lane == 2'(i)) res_r[3*i +: 3] <= bus.add_sum;
                        end
                    end
                end
                DONE: begin
                    last  <= lane;
                    gnt_r <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt    = gnt_r;
    assign bus.done   = done_r;
    assign bus.res    = res_r;
    assign bus.add_a  = add_a_r;
    assign bus.add_b  = add_b_r;
    assign bus.add_go = add_go_r;
    assign bus.busy   = busy_r;

endmodule
